// File: rtl/cnt_down_if.sv
// Handshake bundle for the loadable down-counter: controls in, count and status out.
interface cnt_down_if #(parameter int WIDTH = 4);
  logic             en;
  logic             load;
  logic             mode;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] cnt;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (output en, load, mode, din, input cnt, zero, busy, done);
  modport slave  (input en, load, mode, din, output cnt, zero, busy, done);
endinterface

// File: rtl/cnt_down.sv
// Loadable down-counting timer with one-cycle done pulse on expiry.
// Optional periodic auto-reload compiled in with CNT_DOWN_RELOAD_EN.
module cnt_down #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       clr,
  cnt_down_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rld_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      done_q  <= done_d;
    end
  end

  // load beats any decrement, including the terminal one, so no done on collision
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    done_d  = 1'b0;
    if (bus.load) begin
      cnt_d   = bus.din;
      rld_d   = bus.din;
      state_d = (bus.din != '0) ? RUN : IDLE;
    end else if (state_q == RUN && bus.en) begin
      if (cnt_q == WIDTH'(1)) begin
        done_d = 1'b1;
`ifdef CNT_DOWN_RELOAD_EN
        if (bus.mode) begin
          cnt_d = rld_q;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
`else
        cnt_d   = '0;
        state_d = IDLE;
`endif
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

`ifndef CNT_DOWN_RELOAD_EN
  logic unused_mode;
  assign unused_mode = bus.mode;
`endif

  assign bus.cnt  = cnt_q;
  assign bus.zero = (cnt_q == '0);
  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;

endmodule

// File: tb/tb_cnt_down.sv
// Directed self-checking bench for cnt_down; reload expectations follow CNT_DOWN_RELOAD_EN.
module tb_cnt_down;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cnt_down_if #(.WIDTH(4)) bus ();

  cnt_down #(.WIDTH(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.load = 1'b0; bus.mode = 1'b0; bus.din = '0;
    step(); step();
    clr = 1'b0;
    bus.load = 1'b1; bus.din = 4'd6;
    step();
    bus.load = 1'b0;
    checks++;
    if (bus.cnt !== 4'd6) begin errors++; $display("FAIL reset_preload cnt: got %0d want 6", bus.cnt); end
    #3 clr = 1'b1;
    #1;
    checks++;
    if (bus.cnt !== 4'd0 || bus.busy !== 1'b0 || bus.zero !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got cnt=%0d busy=%b zero=%b done=%b want 0/0/1/0",
               bus.cnt, bus.busy, bus.zero, bus.done);
    end
    step();
    clr = 1'b0;
    bus.en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.cnt !== 4'd0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle_en cyc %0d: got cnt=%0d busy=%b want 0/0", i, bus.cnt, bus.busy);
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_oneshot();
    int exp;
    bus.load = 1'b1; bus.din = 4'd5;
    step();
    bus.load = 1'b0; bus.en = 1'b1;
    checks++;
    if (bus.cnt !== 4'd5 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL oneshot_load: got cnt=%0d busy=%b want 5/1", bus.cnt, bus.busy);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      exp = 5 - i;
      checks++;
      if (bus.cnt !== 4'(exp) || bus.done !== (exp == 0) || bus.busy !== (exp != 0) || bus.zero !== (exp == 0)) begin
        errors++;
        $display("FAIL oneshot step %0d: got cnt=%0d done=%b busy=%b zero=%b want cnt=%0d",
                 i, bus.cnt, bus.done, bus.busy, bus.zero, exp);
      end
    end
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.cnt !== 4'd0) begin
      errors++; $display("FAIL oneshot_done_width: got done=%b cnt=%0d want 0/0", bus.done, bus.cnt);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_enable();
    logic [4:0] pat;
    logic [3:0] exp_cnt [5];
    logic [4:0] exp_done;
    pat = 5'b11001;   // applied LSB first: 1,0,0,1,1
    exp_cnt = '{4'd2, 4'd2, 4'd2, 4'd1, 4'd0};
    exp_done = 5'b10000;
    bus.load = 1'b1; bus.din = 4'd3;
    step();
    bus.load = 1'b0;
    checks++;
    if (bus.cnt !== 4'd3) begin errors++; $display("FAIL enable_load: got %0d want 3", bus.cnt); end
    for (int i = 0; i < 5; i++) begin
      bus.en = pat[i];
      step();
      checks++;
      if (bus.cnt !== exp_cnt[i] || bus.done !== exp_done[i]) begin
        errors++;
        $display("FAIL enable step %0d: got cnt=%0d done=%b want cnt=%0d done=%b",
                 i, bus.cnt, bus.done, exp_cnt[i], exp_done[i]);
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_load_priority();
    bus.load = 1'b1; bus.din = 4'd2; bus.en = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    checks++;
    if (bus.cnt !== 4'd1) begin errors++; $display("FAIL prio_setup: got %0d want 1", bus.cnt); end
    bus.load = 1'b1; bus.din = 4'd9;
    step();
    checks++;
    if (bus.cnt !== 4'd9 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL prio_load9: got cnt=%0d done=%b busy=%b want 9/0/1", bus.cnt, bus.done, bus.busy);
    end
    bus.din = 4'd0;
    step();
    checks++;
    if (bus.cnt !== 4'd0 || bus.busy !== 1'b0 || bus.zero !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL prio_load0: got cnt=%0d busy=%b zero=%b done=%b want 0/0/1/0",
               bus.cnt, bus.busy, bus.zero, bus.done);
    end
    bus.load = 1'b0;
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.cnt !== 4'd0) begin
      errors++; $display("FAIL prio_after: got done=%b cnt=%0d want 0/0", bus.done, bus.cnt);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_reload();
    int  exp;
    bit  exp_done;
    bus.mode = 1'b1;
    bus.load = 1'b1; bus.din = 4'd3;
    step();
    bus.load = 1'b0; bus.en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
`ifdef CNT_DOWN_RELOAD_EN
      exp = 3 - (i % 3);
      exp_done = (i % 3 == 0);
`else
      exp = (i < 3) ? 3 - i : 0;
      exp_done = (i == 3);
`endif
      checks++;
      if (bus.cnt !== 4'(exp) || bus.done !== exp_done || bus.zero !== (exp == 0)) begin
        errors++;
        $display("FAIL reload step %0d: got cnt=%0d done=%b zero=%b want cnt=%0d done=%b",
                 i, bus.cnt, bus.done, bus.zero, exp, exp_done);
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit exp_done;
    int exp;
    bus.mode = 1'b1;
    bus.load = 1'b1; bus.din = 4'd1;
    step();
    bus.load = 1'b0; bus.en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
`ifdef CNT_DOWN_RELOAD_EN
      exp = 1; exp_done = 1'b1;
`else
      exp = 0; exp_done = (i == 1);
`endif
      checks++;
      if (bus.cnt !== 4'(exp) || bus.done !== exp_done) begin
        errors++;
        $display("FAIL b2b step %0d: got cnt=%0d done=%b want cnt=%0d done=%b",
                 i, bus.cnt, bus.done, exp, exp_done);
      end
    end
    bus.en = 1'b0; bus.mode = 1'b0;
    bus.load = 1'b1; bus.din = 4'd0;
    step();
    bus.load = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.load = 1'b1; bus.din = 4'd15;
    step();
    bus.load = 1'b0; bus.en = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (bus.cnt !== 4'd7) begin errors++; $display("FAIL rstmid_count: got %0d want 7", bus.cnt); end
    #3 clr = 1'b1;
    #1;
    checks++;
    if (bus.cnt !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort: got cnt=%0d busy=%b done=%b want 0/0/0", bus.cnt, bus.busy, bus.done);
    end
    step();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (bus.done !== 1'b0 || bus.cnt !== 4'd0) begin
        errors++;
        $display("FAIL rstmid_after cyc %0d: got done=%b cnt=%0d want 0/0", i, bus.done, bus.cnt);
      end
    end
    bus.en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_enable();
    test_load_priority();
    test_reload();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnt_down.md
# cnt_down

Loadable down-counting timer, the counterpart to the team's 4-bit up-counter: instead of counting up from clear, it is loaded with a value and counts down to zero. On expiry it raises a one-cycle `done` pulse. It sits beside the up-counter in the P1 counter exercises and serves as the cycle-delay and timeout element for later controller blocks. A compile-time option adds periodic auto-reload.

## Interface
- `WIDTH`, default 4: counter and load-value width.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `clr` input, 1 bit: asynchronous, active-high reset.
- `en` input, 1 bit: count enable; decrement only when high and in RUN.
- `load` input, 1 bit: synchronous load strobe; has priority over `en`.
- `din` input, WIDTH bits: load value, sampled when `load`=1.
- `mode` input, 1 bit: 0 = one-shot, 1 = auto-reload. Only honoured when `CNT_DOWN_RELOAD_EN` is defined.
- `cnt` output, WIDTH bits: current count, registered.
- `zero` output, 1 bit: combinational `cnt == 0`.
- `busy` output, 1 bit: high while in RUN.
- `done` output, 1 bit: registered one-cycle expiry pulse.

## Operation
- State machine has two states:
  - IDLE: counter holds, `en` is ignored.
  - RUN: counter decrements on enable.
- Internal register `rld` (WIDTH bits) holds the last loaded value.
- Reset (`clr`=1, asynchronous) sets:
  - state=IDLE, `cnt`=0, `rld`=0, `done`=0.
  - Therefore `busy`=0 and `zero`=1.
- `load`=1, any state:
  - `cnt`<=`din` and `rld`<=`din`.
  - Next state is RUN if `din`!=0, otherwise IDLE.
  - `done`<=0.
- RUN, `load`=0, `en`=0: `cnt` holds, `done`<=0.
- RUN, `load`=0, `en`=1, `cnt`>1: `cnt`<=`cnt`-1, `done`<=0.
- RUN, `load`=0, `en`=1, `cnt`==1 (terminal decrement):
  - `done`<=1 in every mode.
  - One-shot: `cnt`<=0, next state IDLE.
  - Auto-reload: `cnt`<=`rld`, stays in RUN, `zero` never asserts.
- IDLE, `load`=0: `cnt` and `rld` hold, `done`<=0.
- Arithmetic is unsigned modulo 2^WIDTH. The counter never underflows, because no decrement happens from 0 (0 is only held in IDLE).
- Simultaneous `load` and terminal decrement: `load` wins. The new value is taken and no `done` pulse is produced.
- `mode` is sampled at the terminal decrement only, so changing it mid-count takes effect at the next expiry.
- `clr` asserted mid-count aborts immediately to the reset values. A pending `done` is lost.

## Timing
- Load latency: `load` sampled at edge k gives `cnt`=`din` and `busy`=1 after edge k.
- With `en` held high from edge k+1, `cnt` is 0 after edge k+`din`.
  - `done` is high during the cycle following edge k+`din`.
  - `busy` falls at that same edge (one-shot).
- `done` width is exactly one clock. Back-to-back pulses occur only in auto-reload with `rld`=1 (period 1).
- Auto-reload period is `rld` enabled cycles between `done` pulses.
- `zero` follows `cnt` combinationally with no added latency.
- Outputs change only on `clk` rising edges or asynchronously on `clr`.

## Configuration
- Macro: `CNT_DOWN_RELOAD_EN`.
- Defined: auto-reload path compiled in. `mode`=1 reloads `rld` at expiry and stays in RUN.
- Undefined: the `mode` port remains but is ignored. Every expiry is one-shot (`cnt`<=0, IDLE), and `rld` may be optimised away.

## Test plan
- Reset then idle: assert `clr` mid-cycle → immediately `cnt`=0, `busy`=0, `zero`=1, `done`=0. Then pulse `en` for 5 cycles → `cnt` stays 0.
- One-shot countdown: `load` `din`=5, then `en`=1 continuously → `cnt` reads 5,4,3,2,1,0. `done`=1 for exactly one cycle when `cnt`=0, and `busy` drops in that same cycle.
- Enable gating: `load` 3, `en` pattern 1,0,0,1,1 → `cnt` reads 3,2,2,2,1,0, with `done` only after the final decrement.
- Load priority: with `cnt`=1 and `en`=1, assert `load` with `din`=9 → `cnt`=9, `done`=0, `busy`=1. Load with `din`=0 → IDLE, `zero`=1, no `done`.
- Auto-reload (macro defined, `mode`=1): `load` 3, `en` high for 9 cycles → `cnt` 3,2,1,3,2,1,…, with `done` pulsed every 3 cycles and `zero` never high. With the macro undefined, the same stimulus gives one `done` and then IDLE with `cnt`=0.
- Reset mid-operation: `load` 15, count to 7, assert `clr` → `cnt`=0, state IDLE, and no `done` pulse afterwards.
